// File: rtl/occupancy_pkg.sv
// Shared types and constants for the occupancy-grid datapath.
//
// Contents:
//   X_WIDTH / Y_WIDTH / ERR_WIDTH : grid index widths and Bresenham error width
//   grid_x_t, grid_y_t            : unsigned grid indices
//   err_t                         : signed Bresenham error / delta type
//   tracer_state_t                : ray tracer FSM states
//   mag_x / mag_y                 : |a-b| of two grid indices, widened to err_t
//
// ERR_WIDTH has to satisfy 2^(ERR_WIDTH-1) > 2*max(2^X_WIDTH-1, 2^Y_WIDTH-1).
// With that margin, 2*err cannot overflow the signed error type.
package occupancy_pkg;

  localparam int X_WIDTH   = 5;
  localparam int Y_WIDTH   = 4;
  localparam int ERR_WIDTH = 8;

  typedef logic [X_WIDTH-1:0]          grid_x_t;
  typedef logic [Y_WIDTH-1:0]          grid_y_t;
  typedef logic signed [ERR_WIDTH-1:0] err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } tracer_state_t;

  // Unsigned distance between two x indices, zero-extended into err_t.
  function automatic err_t mag_x(grid_x_t a, grid_x_t b);
    grid_x_t d;
    d = (a >= b) ? (a - b) : (b - a);
    return err_t'({{(ERR_WIDTH-X_WIDTH){1'b0}}, d});
  endfunction

  // Unsigned distance between two y indices, zero-extended into err_t.
  function automatic err_t mag_y(grid_y_t a, grid_y_t b);
    grid_y_t d;
    d = (a >= b) ? (a - b) : (b - a);
    return err_t'({{(ERR_WIDTH-Y_WIDTH){1'b0}}, d});
  endfunction

endpackage

// File: rtl/ray_cell_tracer_if.sv
// Bundle of the ray request handshake and the cell output stream.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that transfer; ready may toggle freely and is ignored
// while valid is low.
//
// Signals:
//   ray_valid / ray_ready                  : ray request channel
//   x_origin, y_origin, x_end, y_end       : ray payload (grid indices)
//   cell_valid / cell_ready                : cell stream channel
//   cell_x, cell_y, cell_is_free, cell_last: cell payload
//   state_dbg                              : tracer FSM state, observation only
//
// Modports:
//   slave  : the tracer (consumes rays, produces cells)
//   master : the environment (issues rays, consumes cells)
interface ray_cell_tracer_if;
  import occupancy_pkg::*;

  logic          ray_valid;
  logic          ray_ready;
  grid_x_t       x_origin;
  grid_y_t       y_origin;
  grid_x_t       x_end;
  grid_y_t       y_end;

  logic          cell_valid;
  logic          cell_ready;
  grid_x_t       cell_x;
  grid_y_t       cell_y;
  logic          cell_is_free;
  logic          cell_last;

  tracer_state_t state_dbg;

  modport slave (
    input  ray_valid, x_origin, y_origin, x_end, y_end, cell_ready,
    output ray_ready, cell_valid, cell_x, cell_y, cell_is_free, cell_last,
    output state_dbg
  );

  modport master (
    output ray_valid, x_origin, y_origin, x_end, y_end, cell_ready,
    input  ray_ready, cell_valid, cell_x, cell_y, cell_is_free, cell_last,
    input  state_dbg
  );

endinterface

// File: rtl/bresenham_step.sv
// One integer Bresenham step, purely combinational.
//
// Inputs:
//   x, y           : current cell
//   err            : current error term
//   dx             : |x_end - x_origin| (non-negative)
//   dy             : -|y_end - y_origin| (non-positive)
//   sx_neg, sy_neg : 1 = step towards lower index, 0 = towards higher index
// Outputs:
//   x_next, y_next, err_next : state after one step
//
// Both axis conditions are judged against e2 = 2*err taken before the step;
// the y update adds dx to the error already corrected by the x update, so a
// diagonal move applies both corrections.
module bresenham_step
  import occupancy_pkg::*;
(
  input  grid_x_t x,
  input  grid_y_t y,
  input  err_t    err,
  input  err_t    dx,
  input  err_t    dy,
  input  logic    sx_neg,
  input  logic    sy_neg,
  output grid_x_t x_next,
  output grid_y_t y_next,
  output err_t    err_next
);

  err_t e2;
  err_t err_mid;

  always_comb begin
    e2       = err <<< 1;
    err_mid  = err;
    x_next   = x;
    y_next   = y;

    if (e2 >= dy) begin
      err_mid = err + dy;
      x_next  = sx_neg ? (x - 1'b1) : (x + 1'b1);
    end

    err_next = err_mid;
    if (e2 <= dx) begin
      err_next = err_mid + dx;
      y_next   = sy_neg ? (y - 1'b1) : (y + 1'b1);
    end
  end

endmodule

// File: rtl/ray_cell_tracer.sv
// Ray cell tracer: accepts one laser ray (sensor cell -> hit cell) and walks
// it with integer Bresenham, emitting one grid cell per output handshake.
// Every traversed cell is reported free; the hit cell is reported occupied
// and flagged as the last cell of the ray.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; returns to IDLE and discards any ray
//   bus   : ray request channel in, cell stream channel out (slave modport)
//
// Flow: IDLE accepts and latches a ray, SETUP derives deltas, directions and
// the initial error, EMIT presents the current cell and advances one step per
// handshake until the hit cell has been consumed.
module ray_cell_tracer
  import occupancy_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  ray_cell_tracer_if.slave  bus
);

  tracer_state_t state_q;
  tracer_state_t state_d;

  grid_x_t cur_x;
  grid_y_t cur_y;
  grid_x_t end_x;
  grid_y_t end_y;
  err_t    dx_q;
  err_t    dy_q;
  err_t    err_q;
  logic    sx_neg_q;
  logic    sy_neg_q;

  grid_x_t step_x;
  grid_y_t step_y;
  err_t    step_err;

  logic at_end;
  logic cell_fire;

  assign at_end    = (cur_x == end_x) && (cur_y == end_y);
  assign cell_fire = (state_q == EMIT) && bus.cell_ready;

  bresenham_step u_step (
    .x        (cur_x),
    .y        (cur_y),
    .err      (err_q),
    .dx       (dx_q),
    .dy       (dy_q),
    .sx_neg   (sx_neg_q),
    .sy_neg   (sy_neg_q),
    .x_next   (step_x),
    .y_next   (step_y),
    .err_next (step_err)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ray_valid) state_d = SETUP;
      SETUP:   state_d = EMIT;
      EMIT:    if (cell_fire && at_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk datapath. The origin is latched straight into the current cell in
  // IDLE, so SETUP only has to derive the deltas from it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_x    <= '0;
      cur_y    <= '0;
      end_x    <= '0;
      end_y    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ray_valid) begin
            cur_x <= bus.x_origin;
            cur_y <= bus.y_origin;
            end_x <= bus.x_end;
            end_y <= bus.y_end;
          end
        end
        SETUP: begin
          dx_q     <= mag_x(end_x, cur_x);
          dy_q     <= -mag_y(end_y, cur_y);
          err_q    <= mag_x(end_x, cur_x) - mag_y(end_y, cur_y);
          sx_neg_q <= (end_x < cur_x);
          sy_neg_q <= (end_y < cur_y);
        end
        EMIT: begin
          // A stalled output (cell_ready low) leaves everything untouched.
          if (cell_fire && !at_end) begin
            cur_x <= step_x;
            cur_y <= step_y;
            err_q <= step_err;
          end
        end
        default: ;
      endcase
    end
  end

  // ray_ready is gated with reset so it reads low throughout reset and rises
  // in the first cycle after release.
  assign bus.ray_ready    = (state_q == IDLE) && !reset;
  assign bus.cell_valid   = (state_q == EMIT);
  assign bus.cell_x       = cur_x;
  assign bus.cell_y       = cur_y;
  assign bus.cell_is_free = (state_q == EMIT) && !at_end;
  assign bus.cell_last    = (state_q == EMIT) && at_end;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_ray_cell_tracer.sv
// Bench for ray_cell_tracer: directed rays from the test plan plus random
// rays under random backpressure, checked by a scoreboard monitor.
module tb_ray_cell_tracer;
  import occupancy_pkg::*;

  localparam int CW = X_WIDTH + Y_WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ray_cell_tracer_if bus ();

  ray_cell_tracer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];
  int            cnt_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            n_hs     = 0;
  int            ray_cells = 0;
  logic          prev_stall = 1'b0;
  logic [CW-1:0] prev_cell;
  logic [CW-1:0] mon_cur;
  logic [CW-1:0] mon_exp;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [CW-1:0] pack_cell(int x, int y, bit is_free);
    return {grid_x_t'(x), grid_y_t'(y), is_free, ~is_free};
  endfunction

  // Reference walk: textbook integer Bresenham on plain ints.
  task automatic model_ray(int x0, int y0, int x1, int y1);
    int dx, dy, sx, sy, err, e2, x, y, n;
    bit done;
    dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 >= y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0; n = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      done = (x == x1) && (y == y1);
      exp_q.push_back(pack_cell(x, y, !done));
      n++;
      if (!done) begin
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
    cnt_q.push_back(n);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      mon_cur = {bus.cell_x, bus.cell_y, bus.cell_is_free, bus.cell_last};
      if (prev_stall) begin
        check("stall_valid_held", bus.cell_valid, 1);
        check("stall_cell_held", mon_cur, prev_cell);
      end
      if (bus.cell_valid && bus.cell_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cell actual=%0h required=none at %0t", mon_cur, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cell", mon_cur, mon_exp);
        end
        n_hs++;
        ray_cells++;
        if (bus.cell_last) begin
          if (cnt_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cell_count actual=%0d required=none", ray_cells);
          end else begin
            check("cell_count", ray_cells, cnt_q.pop_front());
          end
          ray_cells = 0;
        end
      end
      prev_stall = bus.cell_valid && !bus.cell_ready;
      prev_cell  = mon_cur;
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks enter and leave at 1 time unit after a rising edge.
  task automatic send_ray(int x0, int y0, int x1, int y1, bit use_model, bit chk_lat);
    int t;
    t = 0;
    while (!bus.ray_ready && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    check("ray_ready_wait", bus.ray_ready, 1);
    if (use_model) model_ray(x0, y0, x1, y1);
    bus.x_origin  = grid_x_t'(x0);
    bus.y_origin  = grid_y_t'(y0);
    bus.x_end     = grid_x_t'(x1);
    bus.y_end     = grid_y_t'(y1);
    bus.ray_valid = 1'b1;
    @(posedge clock); #1;
    bus.ray_valid = 1'b0;
    if (chk_lat) begin
      check("lat_setup_no_valid", bus.cell_valid, 0);
      @(posedge clock); #1;
      check("lat_first_valid", bus.cell_valid, 1);
    end
  endtask

  task automatic wait_done(bit rand_bp, int budget);
    int t;
    t = 0;
    while (t < budget && !(exp_q.size() == 0 && bus.ray_ready && !bus.cell_valid)) begin
      @(posedge clock); #1;
      if (rand_bp) bus.cell_ready = ($urandom_range(0, 3) != 0);
      t++;
    end
    check("ray_done", (exp_q.size() == 0) && bus.ray_ready, 1);
    bus.cell_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int steep_x[8];
    int steep_y[8];
    int base;
    int t;
    steep_x = '{10, 10, 11, 11, 11, 11, 12, 12};
    steep_y = '{2, 3, 4, 5, 6, 7, 8, 9};

    reset          = 1'b1;
    bus.ray_valid  = 1'b0;
    bus.x_origin   = '0;
    bus.y_origin   = '0;
    bus.x_end      = '0;
    bus.y_end      = '0;
    bus.cell_ready = 1'b1;

    repeat (2) begin @(posedge clock); #1; end
    check("rst_ray_ready", bus.ray_ready, 0);
    check("rst_cell_valid", bus.cell_valid, 0);
    check("rst_cell_x", bus.cell_x, 0);
    check("rst_cell_y", bus.cell_y, 0);
    check("rst_cell_is_free", bus.cell_is_free, 0);
    check("rst_cell_last", bus.cell_last, 0);
    check("rst_state", bus.state_dbg, IDLE);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_ray_ready", bus.ray_ready, 1);

    // Horizontal: 6 cells back to back, idle 6 cycles after the first cell.
    send_ray(0, 0, 5, 0, 1, 1);
    repeat (6) begin @(posedge clock); #1; end
    check("horiz_idle", bus.ray_ready, 1);
    check("horiz_all_cells", exp_q.size(), 0);

    // Steep ray against a hand-derived cell list.
    for (int i = 0; i < 8; i++) exp_q.push_back(pack_cell(steep_x[i], steep_y[i], i != 7));
    cnt_q.push_back(8);
    send_ray(10, 2, 12, 9, 0, 0);
    wait_done(0, 50);

    // Reverse corner: negative steps on both axes.
    send_ray(31, 15, 0, 0, 1, 0);
    wait_done(0, 80);

    // Origin equals end: single occupied cell, idle again two cycles later.
    send_ray(7, 7, 7, 7, 1, 0);
    check("single_ready_low_setup", bus.ray_ready, 0);
    @(posedge clock); #1;
    check("single_valid", bus.cell_valid, 1);
    check("single_ready_low_emit", bus.ray_ready, 0);
    @(posedge clock); #1;
    check("single_ready_back", bus.ray_ready, 1);
    check("single_consumed", exp_q.size(), 0);

    // Backpressure on the second cell, with a ray request pulsed mid-ray.
    send_ray(0, 0, 3, 3, 1, 1);
    @(posedge clock); #1;
    bus.cell_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.x_origin  = grid_x_t'(9);
        bus.y_origin  = grid_y_t'(9);
        bus.x_end     = grid_x_t'(1);
        bus.y_end     = grid_y_t'(1);
        bus.ray_valid = 1'b1;
        check("busy_ray_ready_low", bus.ray_ready, 0);
      end else begin
        bus.ray_valid = 1'b0;
      end
      @(posedge clock); #1;
    end
    bus.ray_valid = 1'b0;
    check("bp_held_x", bus.cell_x, 1);
    check("bp_held_y", bus.cell_y, 1);
    bus.cell_ready = 1'b1;
    wait_done(0, 20);
    repeat (3) begin @(posedge clock); #1; end
    check("bp_no_extra_ray", bus.cell_valid, 0);

    // Reset during the third cell of a long ray.
    base = n_hs;
    send_ray(0, 0, 20, 0, 1, 0);
    t = 0;
    while (n_hs < base + 2 && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check("rst_mid_third_cell", bus.cell_x, 2);
    reset = 1'b1;
    #1;
    check("rst_mid_valid_drop", bus.cell_valid, 0);
    check("rst_mid_ray_ready", bus.ray_ready, 0);
    exp_q.delete();
    cnt_q.delete();
    ray_cells = 0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    check("rst_mid_release_ready", bus.ray_ready, 1);
    check("rst_mid_state", bus.state_dbg, IDLE);
    send_ray(2, 2, 2, 4, 1, 0);
    wait_done(0, 20);

    // Random rays under random backpressure.
    for (int r = 0; r < 25; r++) begin
      send_ray($urandom_range(0, 31), $urandom_range(0, 15),
               $urandom_range(0, 31), $urandom_range(0, 15), 1, 0);
      wait_done(1, 600);
    end

    repeat (4) begin @(posedge clock); #1; end
    check("final_queue_empty", exp_q.size(), 0);
    check("final_count_queue_empty", cnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
